// File: rtl/spi_pkg.sv
// Shared definitions for the mode-0 SPI slave: default widths, frame layout,
// RW encodings and FSM state encoding.
package spi_pkg;

    localparam int unsigned SYNC_STAGES_DEF = 2;
    localparam int unsigned ADDR_W_DEF      = 7;
    localparam int unsigned DATA_W_DEF      = 8;
    localparam int unsigned FRAME_W_DEF     = 1 + ADDR_W_DEF + DATA_W_DEF;

    localparam int unsigned RW_BIT   = 15;
    localparam int unsigned ADDR_MSB = 14;
    localparam int unsigned ADDR_LSB = 8;
    localparam int unsigned DATA_MSB = 7;
    localparam int unsigned DATA_LSB = 0;

    localparam logic RW_WRITE = 1'b1;
    localparam logic RW_READ  = 1'b0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_DATA,
        ST_DONE,
        ST_WAIT_CS
    } state_t;

    // Assemble a default-width frame {RW, ADDR, DATA}
    function automatic logic [FRAME_W_DEF-1:0] mk_frame(
        input logic                  rw,
        input logic [ADDR_W_DEF-1:0] addr,
        input logic [DATA_W_DEF-1:0] data
    );
        logic [FRAME_W_DEF-1:0] f;
        f                    = '0;
        f[RW_BIT]            = rw;
        f[ADDR_MSB:ADDR_LSB] = addr;
        f[DATA_MSB:DATA_LSB] = data;
        return f;
    endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// N-stage synchronizer for an asynchronous level, with single-cycle rise and
// fall pulses derived from the synchronized value.
module spi_sync_edge #(
    parameter int unsigned STAGES = 2
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_async,
    output logic o_rise_c,
    output logic o_fall_c
);

    logic [STAGES-1:0] r_sync;
    logic              r_prev;

    // Resetting to 0 means a line held low across reset produces no fall pulse
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync <= '0;
            r_prev <= 1'b0;
        end else begin
            r_sync <= {r_sync[STAGES-2:0], i_async};
            r_prev <= r_sync[STAGES-1];
        end
    end

    assign o_rise_c = r_sync[STAGES-1] & ~r_prev;
    assign o_fall_c = ~r_sync[STAGES-1] & r_prev;

endmodule

// File: rtl/spi_s.sv
// Mode-0 SPI slave: oversamples CSN/SCLK/MOSI in the CLK domain, decodes
// {RW, ADDR, DATA} frames into register-bank strobes and returns read data on MISO.
module spi_s
    import spi_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEF,
    parameter int unsigned ADDR_W      = ADDR_W_DEF,
    parameter int unsigned DATA_W      = DATA_W_DEF
) (
    input  logic              CLK,
    input  logic              RSTN,
    input  logic              CSN,
    input  logic              SCLK,
    input  logic              MOSI,
    output logic              MISO,
    output logic [ADDR_W-1:0] REG_ADDR,
    output logic [DATA_W-1:0] REG_WDATA,
    output logic              REG_WE,
    output logic              REG_RE,
    input  logic [DATA_W-1:0] REG_RDATA,
    output logic              WR_DONE,
    output logic              RD_DONE,
    output logic              FRAME_ERR
);

    localparam int unsigned FRAME_W = 1 + ADDR_W + DATA_W;
    localparam int unsigned CNT_W   = $clog2(FRAME_W + 1);
    localparam int unsigned RX_W    = (ADDR_W > DATA_W - 1) ? ADDR_W : DATA_W - 1;
    localparam logic [CNT_W-1:0] CMD_LAST   = CNT_W'(ADDR_W);
    localparam logic [CNT_W-1:0] FRAME_LAST = CNT_W'(FRAME_W - 1);

    logic w_csn_rise, w_csn_fall, w_sclk_rise, w_sclk_fall, w_mosi;
    logic [SYNC_STAGES-1:0] r_mosi_sync;

    spi_sync_edge #(.STAGES(SYNC_STAGES)) u_csn_sync (
        .i_clk    (CLK),
        .i_rst_n  (RSTN),
        .i_async  (CSN),
        .o_rise_c (w_csn_rise),
        .o_fall_c (w_csn_fall)
    );

    spi_sync_edge #(.STAGES(SYNC_STAGES)) u_sclk_sync (
        .i_clk    (CLK),
        .i_rst_n  (RSTN),
        .i_async  (SCLK),
        .o_rise_c (w_sclk_rise),
        .o_fall_c (w_sclk_fall)
    );

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) r_mosi_sync <= '0;
        else       r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], MOSI};
    end
    assign w_mosi = r_mosi_sync[SYNC_STAGES-1];

    state_t            r_state, w_state_n;
    logic [CNT_W-1:0]  r_cnt, w_cnt_n;
    logic [RX_W-1:0]   r_rx, w_rx_n;
    logic [RX_W:0]     w_rx_next;
    logic [DATA_W-1:0] r_tx, w_tx_n;
    logic              r_rw, w_rw_n;
    logic [ADDR_W-1:0] r_addr, w_addr_n;
    logic              r_cs_rose, w_cs_rose_n;
    logic              r_cap_pend, w_cap_pend_n;
    logic              r_miso, w_miso_n;
    logic [ADDR_W-1:0] r_reg_addr, w_reg_addr_n;
    logic [DATA_W-1:0] r_reg_wdata, w_reg_wdata_n;
    logic              r_reg_we, w_reg_we_n;
    logic              r_reg_re, w_reg_re_n;
    logic              r_wr_done, w_wr_done_n;
    logic              r_rd_done, w_rd_done_n;
    logic              r_frame_err, w_frame_err_n;
    logic              w_last_rise;

    assign w_rx_next   = {r_rx, w_mosi};
    assign w_last_rise = w_sclk_rise && (r_cnt == FRAME_LAST);

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_rx        <= '0;
            r_tx        <= '0;
            r_rw        <= 1'b0;
            r_addr      <= '0;
            r_cs_rose   <= 1'b0;
            r_cap_pend  <= 1'b0;
            r_miso      <= 1'b0;
            r_reg_addr  <= '0;
            r_reg_wdata <= '0;
            r_reg_we    <= 1'b0;
            r_reg_re    <= 1'b0;
            r_wr_done   <= 1'b0;
            r_rd_done   <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_state     <= w_state_n;
            r_cnt       <= w_cnt_n;
            r_rx        <= w_rx_n;
            r_tx        <= w_tx_n;
            r_rw        <= w_rw_n;
            r_addr      <= w_addr_n;
            r_cs_rose   <= w_cs_rose_n;
            r_cap_pend  <= w_cap_pend_n;
            r_miso      <= w_miso_n;
            r_reg_addr  <= w_reg_addr_n;
            r_reg_wdata <= w_reg_wdata_n;
            r_reg_we    <= w_reg_we_n;
            r_reg_re    <= w_reg_re_n;
            r_wr_done   <= w_wr_done_n;
            r_rd_done   <= w_rd_done_n;
            r_frame_err <= w_frame_err_n;
        end
    end

    always_comb begin
        w_state_n     = r_state;
        w_cnt_n       = r_cnt;
        w_rx_n        = r_rx;
        w_tx_n        = r_tx;
        w_rw_n        = r_rw;
        w_addr_n      = r_addr;
        w_cs_rose_n   = r_cs_rose;
        w_cap_pend_n  = r_reg_re;
        w_miso_n      = r_miso;
        w_reg_addr_n  = r_reg_addr;
        w_reg_wdata_n = r_reg_wdata;
        w_reg_we_n    = 1'b0;
        w_reg_re_n    = 1'b0;
        w_wr_done_n   = 1'b0;
        w_rd_done_n   = 1'b0;
        w_frame_err_n = 1'b0;

        // Read data is valid the cycle after REG_RE; capture independent of state
        if (r_cap_pend) w_tx_n = REG_RDATA;

        unique case (r_state)
            ST_IDLE: begin
                w_miso_n = 1'b0;
                if (w_csn_fall) begin
                    w_state_n   = ST_CMD;
                    w_cnt_n     = '0;
                    w_rx_n      = '0;
                    w_cs_rose_n = 1'b0;
                end
            end
            ST_CMD: begin
                w_miso_n = 1'b0;
                if (w_csn_rise) begin
                    w_state_n     = ST_IDLE;
                    w_frame_err_n = 1'b1;
                end else if (w_sclk_rise) begin
                    w_rx_n  = w_rx_next[RX_W-1:0];
                    w_cnt_n = r_cnt + CNT_W'(1);
                    if (r_cnt == CMD_LAST) begin
                        w_state_n = ST_DATA;
                        w_rw_n    = w_rx_next[ADDR_W];
                        w_addr_n  = w_rx_next[ADDR_W-1:0];
                        if (w_rx_next[ADDR_W] == RW_READ) begin
                            w_reg_re_n   = 1'b1;
                            w_reg_addr_n = w_rx_next[ADDR_W-1:0];
                        end
                    end
                end
            end
            ST_DATA: begin
                // A CSN rise coinciding with the final SCLK rise still completes the frame
                if (w_csn_rise && !w_last_rise) begin
                    w_state_n     = ST_IDLE;
                    w_frame_err_n = 1'b1;
                    w_miso_n      = 1'b0;
                end else begin
                    if (w_sclk_rise) begin
                        w_rx_n  = w_rx_next[RX_W-1:0];
                        w_cnt_n = r_cnt + CNT_W'(1);
                    end
                    if (w_last_rise) begin
                        w_state_n   = ST_DONE;
                        w_cs_rose_n = w_csn_rise;
                        w_miso_n    = 1'b0;
                        if (r_rw == RW_WRITE) begin
                            w_reg_we_n    = 1'b1;
                            w_reg_addr_n  = r_addr;
                            w_reg_wdata_n = w_rx_next[DATA_W-1:0];
                            w_wr_done_n   = 1'b1;
                        end else begin
                            w_rd_done_n = 1'b1;
                        end
                    end else if (w_sclk_fall && (r_rw == RW_READ)) begin
                        w_miso_n = r_tx[DATA_W-1];
                        w_tx_n   = {r_tx[DATA_W-2:0], 1'b0};
                    end
                end
            end
            ST_DONE: begin
                w_miso_n  = 1'b0;
                w_state_n = (r_cs_rose || w_csn_rise) ? ST_IDLE : ST_WAIT_CS;
            end
            ST_WAIT_CS: begin
                w_miso_n = 1'b0;
                if (w_csn_rise) w_state_n = ST_IDLE;
            end
            default: begin
                w_state_n = ST_IDLE;
                w_miso_n  = 1'b0;
            end
        endcase
    end

    assign MISO      = r_miso;
    assign REG_ADDR  = r_reg_addr;
    assign REG_WDATA = r_reg_wdata;
    assign REG_WE    = r_reg_we;
    assign REG_RE    = r_reg_re;
    assign WR_DONE   = r_wr_done;
    assign RD_DONE   = r_rd_done;
    assign FRAME_ERR = r_frame_err;

endmodule

// File: tb/tb_spi_s.sv
// Directed bench for spi_s: a behavioural SPI master plus a small register bank,
// with pulse monitors and immediate-assertion checks on each transaction.
module tb_spi_s;
    import spi_pkg::*;

    logic       CLK = 1'b0;
    logic       RSTN, CSN, SCLK, MOSI, MISO;
    logic [6:0] REG_ADDR;
    logic [7:0] REG_WDATA, REG_RDATA;
    logic       REG_WE, REG_RE, WR_DONE, RD_DONE, FRAME_ERR;

    int checks = 0;
    int errors = 0;

    spi_s dut (
        .CLK       (CLK),
        .RSTN      (RSTN),
        .CSN       (CSN),
        .SCLK      (SCLK),
        .MOSI      (MOSI),
        .MISO      (MISO),
        .REG_ADDR  (REG_ADDR),
        .REG_WDATA (REG_WDATA),
        .REG_WE    (REG_WE),
        .REG_RE    (REG_RE),
        .REG_RDATA (REG_RDATA),
        .WR_DONE   (WR_DONE),
        .RD_DONE   (RD_DONE),
        .FRAME_ERR (FRAME_ERR)
    );

    always #5 CLK = ~CLK;

    // Register bank: read data appears the cycle after REG_RE
    logic [7:0] mem [0:127];
    always @(posedge CLK) begin
        if (!RSTN) begin
            for (int i = 0; i < 128; i++) mem[i] <= 8'h00;
            mem[7'h2A] <= 8'h3C;
            REG_RDATA  <= 8'h00;
        end else begin
            if (REG_WE) mem[REG_ADDR] <= REG_WDATA;
            if (REG_RE) REG_RDATA <= mem[REG_ADDR];
        end
    end

    int         we_cnt = 0, re_cnt = 0, wrd_cnt = 0, rdd_cnt = 0, ferr_cnt = 0;
    logic [6:0] we_addr = '0, re_addr = '0;
    logic [7:0] we_data = '0;
    time        wr_t = 0, rd_t = 0;

    always @(negedge CLK) begin
        if (REG_WE)    begin we_cnt++; we_addr = REG_ADDR; we_data = REG_WDATA; end
        if (REG_RE)    begin re_cnt++; re_addr = REG_ADDR; end
        if (WR_DONE)   begin wrd_cnt++; wr_t = $time; end
        if (RD_DONE)   begin rdd_cnt++; rd_t = $time; end
        if (FRAME_ERR) ferr_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Mode-0 master: data set while SCLK low, sampled by both sides on the rise
    task automatic xfer(input logic [15:0] fr, input int nbits, input bit cs_lo,
                        input bit cs_hi, output logic [15:0] mi);
        mi = '0;
        if (cs_lo) begin
            CSN = 1'b0;
            repeat (6) @(negedge CLK);
        end
        for (int i = 0; i < nbits; i++) begin
            if (i < 16) MOSI = fr[15-i];
            else        MOSI = 1'b1;
            repeat (5) @(negedge CLK);
            if (i < 16) mi[15-i] = MISO;
            SCLK = 1'b1;
            repeat (5) @(negedge CLK);
            SCLK = 1'b0;
        end
        MOSI = 1'b0;
        if (cs_hi) begin
            repeat (6) @(negedge CLK);
            CSN = 1'b1;
            repeat (8) @(negedge CLK);
        end
    endtask

    int          s_we, s_re, s_wrd, s_rdd, s_ferr;
    logic [15:0] mi;

    task automatic snap();
        s_we = we_cnt; s_re = re_cnt; s_wrd = wrd_cnt; s_rdd = rdd_cnt; s_ferr = ferr_cnt;
    endtask

    initial begin
        RSTN = 1'b0; CSN = 1'b1; SCLK = 1'b0; MOSI = 1'b0;
        repeat (4) @(negedge CLK);
        check("rst_miso", 32'(MISO), 32'h0);
        check("rst_we", 32'(REG_WE), 32'h0);
        check("rst_re", 32'(REG_RE), 32'h0);
        check("rst_addr", 32'(REG_ADDR), 32'h0);
        check("rst_flags", 32'({WR_DONE, RD_DONE, FRAME_ERR}), 32'h0);
        check("rst_state", 32'(dut.r_state), 32'(ST_IDLE));
        RSTN = 1'b1;
        repeat (6) @(negedge CLK);

        // Write 0x15 <- 0xA5
        snap();
        xfer(mk_frame(RW_WRITE, 7'h15, 8'hA5), 16, 1'b1, 1'b1, mi);
        check("wr_we_cnt", 32'(we_cnt - s_we), 32'd1);
        check("wr_addr", 32'(we_addr), 32'h15);
        check("wr_data", 32'(we_data), 32'hA5);
        check("wr_done_cnt", 32'(wrd_cnt - s_wrd), 32'd1);
        check("wr_ferr", 32'(ferr_cnt - s_ferr), 32'd0);
        check("wr_miso", 32'(mi), 32'h0);

        // Read 0x2A, bank holds 0x3C
        snap();
        xfer(mk_frame(RW_READ, 7'h2A, 8'h00), 16, 1'b1, 1'b1, mi);
        check("rd_re_cnt", 32'(re_cnt - s_re), 32'd1);
        check("rd_addr", 32'(re_addr), 32'h2A);
        check("rd_miso_cmd", 32'(mi[15:8]), 32'h00);
        check("rd_miso_data", 32'(mi[7:0]), 32'h3C);
        check("rd_done_cnt", 32'(rdd_cnt - s_rdd), 32'd1);
        check("rd_no_we", 32'(we_cnt - s_we), 32'd0);

        // Abort after 10 bits, then a clean write
        snap();
        xfer(mk_frame(RW_WRITE, 7'h05, 8'h77), 10, 1'b1, 1'b1, mi);
        check("ab_ferr_cnt", 32'(ferr_cnt - s_ferr), 32'd1);
        check("ab_no_we", 32'(we_cnt - s_we), 32'd0);
        check("ab_no_wrd", 32'(wrd_cnt - s_wrd), 32'd0);
        check("ab_state", 32'(dut.r_state), 32'(ST_IDLE));
        snap();
        xfer(mk_frame(RW_WRITE, 7'h06, 8'h11), 16, 1'b1, 1'b1, mi);
        check("ab2_we_cnt", 32'(we_cnt - s_we), 32'd1);
        check("ab2_addr", 32'(we_addr), 32'h06);
        check("ab2_data", 32'(we_data), 32'h11);
        check("ab2_ferr", 32'(ferr_cnt - s_ferr), 32'd0);

        // 18 SCLK cycles in one CSN window
        snap();
        xfer(mk_frame(RW_WRITE, 7'h7F, 8'hFF), 18, 1'b1, 1'b1, mi);
        check("oc_we_cnt", 32'(we_cnt - s_we), 32'd1);
        check("oc_addr", 32'(we_addr), 32'h7F);
        check("oc_data", 32'(we_data), 32'hFF);
        check("oc_wrd_cnt", 32'(wrd_cnt - s_wrd), 32'd1);
        check("oc_ferr", 32'(ferr_cnt - s_ferr), 32'd0);

        // Reset after 12 bits with CSN held low
        snap();
        xfer(mk_frame(RW_WRITE, 7'h0A, 8'h33), 12, 1'b1, 1'b0, mi);
        RSTN = 1'b0;
        repeat (2) @(negedge CLK);
        check("mr_addr", 32'(REG_ADDR), 32'h0);
        check("mr_wdata", 32'(REG_WDATA), 32'h0);
        check("mr_outs", 32'({MISO, REG_WE, REG_RE, WR_DONE, RD_DONE, FRAME_ERR}), 32'h0);
        check("mr_state", 32'(dut.r_state), 32'(ST_IDLE));
        RSTN = 1'b1;
        repeat (4) @(negedge CLK);
        xfer(mk_frame(RW_WRITE, 7'h0B, 8'h44), 16, 1'b0, 1'b1, mi);
        check("mr_no_we", 32'(we_cnt - s_we), 32'd0);
        check("mr_no_wrd", 32'(wrd_cnt - s_wrd), 32'd0);
        check("mr_no_ferr", 32'(ferr_cnt - s_ferr), 32'd0);
        check("mr_state2", 32'(dut.r_state), 32'(ST_IDLE));

        // Back-to-back write 0x01 <- 0x12, read 0x01, CSN high 4 CLK between
        snap();
        xfer(mk_frame(RW_WRITE, 7'h01, 8'h12), 16, 1'b1, 1'b0, mi);
        repeat (6) @(negedge CLK);
        CSN = 1'b1;
        repeat (4) @(negedge CLK);
        xfer(mk_frame(RW_READ, 7'h01, 8'h00), 16, 1'b1, 1'b1, mi);
        check("bb_we_cnt", 32'(we_cnt - s_we), 32'd1);
        check("bb_we_addr", 32'(we_addr), 32'h01);
        check("bb_we_data", 32'(we_data), 32'h12);
        check("bb_re_cnt", 32'(re_cnt - s_re), 32'd1);
        check("bb_re_addr", 32'(re_addr), 32'h01);
        check("bb_miso", 32'(mi), 32'h0012);
        check("bb_done_cnts", 32'({16'(wrd_cnt - s_wrd), 16'(rdd_cnt - s_rdd)}), 32'h0001_0001);
        check("bb_order", 32'(wr_t < rd_t), 32'h1);
        check("bb_ferr", 32'(ferr_cnt - s_ferr), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/spi_s.md
Name: spi_s

Overview:
- SPI slave (mode 0: CPOL=0, CPHA=0); the responder end of the team's SPI master link.
- Oversamples CSN/SCLK/MOSI in the system CLK domain and decodes 16-bit frames, MSB first: {RW, ADDR[6:0], DATA[7:0]}, RW=1 write, RW=0 read.
- Drives a simple synchronous register-bank port and shifts read data back on MISO.

Parameters:
- SYNC_STAGES, 2, flop stages on CSN/SCLK/MOSI before use (min 2).
- ADDR_W, 7, address field width.
- DATA_W, 8, data field width (frame = 1+ADDR_W+DATA_W bits).

Ports:
- CLK  in  1  system clock; all logic on posedge.
- RSTN  in  1  reset, asynchronous, active-low.
- CSN  in  1  chip select from master, active-low, asynchronous to CLK.
- SCLK  in  1  serial clock from master, idle low, asynchronous.
- MOSI  in  1  serial data from master.
- MISO  out  1  serial data to master.
- REG_ADDR  out  ADDR_W  register address, valid with REG_WE/REG_RE.
- REG_WDATA  out  DATA_W  write data, valid with REG_WE.
- REG_WE  out  1  one-cycle write strobe.
- REG_RE  out  1  one-cycle read strobe.
- REG_RDATA  in  DATA_W  read data, valid the CLK cycle after REG_RE.
- WR_DONE  out  1  one-cycle pulse, write frame completed.
- RD_DONE  out  1  one-cycle pulse, read frame completed.
- FRAME_ERR  out  1  one-cycle pulse, CSN rose before 16 bits.

Behaviour:
- Reset: all outputs 0, MISO=0, state IDLE, bit count 0, shift registers 0.
- Sync: CSN, SCLK and MOSI each pass through SYNC_STAGES flops. Edges are detected on the synced SCLK/CSN (rise = prev 0, now 1).
- Timing requirement on the master: SCLK high and low each ≥4 CLK cycles.
- Sampling: MOSI (synced) shifts into rx_shift on the SCLK rise pulse. MISO updates on the SCLK fall pulse.
- States:
  - IDLE: MISO=0. A CSN fall pulse -> CMD, bit_cnt=0.
  - CMD: count bits 0..7. On the 8th rise: latch RW and ADDR.
    - RW=0: assert REG_RE the next cycle, capture REG_RDATA the cycle after into tx_shift -> DATA.
    - RW=1 -> DATA.
  - DATA: bits 8..15.
    - Read: on each fall pulse, MISO <= tx_shift MSB, then shift left. The first data bit is driven on the fall after the 8th rise.
    - Write: MISO stays 0.
    - On the 16th rise -> DONE.
  - DONE: exactly one cycle after the 16th rise.
    - Write: REG_WE=1, REG_ADDR/REG_WDATA = the frame fields, WR_DONE=1.
    - Read: RD_DONE=1.
    - Then -> WAIT_CS.
  - WAIT_CS: extra SCLK edges are ignored, MISO=0. A CSN rise pulse -> IDLE.
- Abort: a CSN rise pulse in CMD or DATA -> IDLE, FRAME_ERR pulse, no REG_WE. A REG_RE already issued is not retracted.
- MISO during CMD: 0.
- REG_ADDR/REG_WDATA hold their last values between strobes.
- CSN rise and SCLK rise in the same cycle: CSN wins (abort), unless that SCLK rise is the 16th bit. In that case the frame completes and then returns to IDLE.
- Reset mid-frame: immediate return to IDLE.
  - If CSN is still low after reset release, the block stays IDLE until a CSN rise then fall is seen.
  - Partial frames are never committed.
- Back-to-back frames: CSN high ≥ SYNC_STAGES+2 CLK cycles must be accepted.

Decomposition:
- Package spi_pkg:
  - Frame field widths/positions: RW bit 15, ADDR 14:8, DATA 7:0.
  - RW encodings: WRITE=1, READ=0.
  - State encoding: IDLE, CMD, DATA, DONE, WAIT_CS.
- Sub-module spi_sync_edge:
  - N-stage synchronizer with rise/fall pulse outputs.
  - Instantiated for CSN and SCLK; MOSI uses the synchronizer only.

Test Plan:
- Write frame, RW=1, ADDR=0x15, DATA=0xA5, SCLK half-period 5 CLK -> single REG_WE with REG_ADDR=0x15, REG_WDATA=0xA5; WR_DONE one pulse; FRAME_ERR=0.
- Read frame, ADDR=0x2A, bank returns 0x3C -> one REG_RE with REG_ADDR=0x2A; master samples 0x3C on bits 8..15 (0,0,1,1,1,1,0,0); MISO=0 during bits 0..7; RD_DONE one pulse.
- Abort: CSN rises after 10 SCLK cycles of a write to 0x05 -> FRAME_ERR one pulse, no REG_WE, state IDLE; the next full write to 0x06 with 0x11 commits correctly.
- Overclock: 18 SCLK cycles within one CSN-low window, write 0x7F/0xFF -> exactly one REG_WE after the 16th rise; edges 17-18 ignored.
- Reset mid-frame: RSTN low after 12 bits with CSN held low, then released -> all outputs 0, no commit; no frame is accepted until CSN rises and falls again.
- Back-to-back: write 0x01/0x12 then read 0x01 with CSN high 4 CLK between -> both frames decoded; WR_DONE then RD_DONE.
